vector_serializer: RTL and testbench

- Parallel-to-serial transmitter sitting directly upstream of the 8-bit serial-to-parallel collector stage.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out on oSignal, one bit per clock, LSB first by default.
- Emits frame-marking strobes and inserts a configurable idle gap between frames so the downstream collector's count/clear period lines up with frame boundaries.

---
 rtl/vector_serializer.sv | 136 +++++++++++++
 tb/tb_vector_serializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vector_serializer.sv
// vector_serializer: parallel-to-serial transmitter feeding an 8-bit collector.
// Accepts one word per valid/ready transfer and shifts it out one bit per
// clock, marking the first and last bit. An optional idle gap follows each
// frame so the frame period lines up with the downstream collector.
module vector_serializer #(
  parameter int WIDTH      = 8,  // bits per frame, 2..32
  parameter bit LSB_FIRST  = 1,  // 1: bit 0 first, 0: bit WIDTH-1 first
  parameter int GAP        = 1,  // idle cycles after each frame, 0..15
  parameter bit IDLE_LEVEL = 0   // line level whenever no data bit is sent
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  output logic             oSignal,
  output logic             oFrame,
  output logic             oFirst,
  output logic             oDone
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);
  localparam logic [3:0]    LAST_GAP   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit            NO_GAP     = (GAP == 0);

  // The state always describes what oSignal is showing in the current cycle,
  // so a transfer in the final cycle of a frame starts the next frame with
  // no bubble.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;  // bits still to be sent, next bit at the head
  logic [CW-1:0]    bit_cnt;    // index of the bit currently on oSignal
  logic [3:0]       gap_cnt;    // index of the gap cycle currently running
  logic             last_bit;
  logic             last_gap;
  logic             take;

  // Bit that leaves the shifter next, depending on transmit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  // Shifter contents once the head bit has been sent.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  // Ready in idle and in the final cycle of a frame; held low during reset.
  always_comb begin
    // NOTE: oReady depends combinationally on iRst_n so no transfer can be
    // signalled upstream while the block is being reset.
    last_bit = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
    last_gap = (state == S_GAP) && (gap_cnt == LAST_GAP);
    oReady   = iRst_n && ((state == S_IDLE) || (last_bit && NO_GAP) || last_gap);
    take     = iValid && oReady;
  end

  // Frame sequencer with registered serial outputs.
  always_ff @(posedge iClk) begin
    // NOTE: every register here uses <= so all state updates in one edge see
    // the same pre-edge values regardless of statement order.
    if (!iRst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      oSignal   <= IDLE_LEVEL;
      oFrame    <= 1'b0;
      oFirst    <= 1'b0;
      oDone     <= 1'b0;
    end else if (take) begin
      // Put the first bit on the line right away; keep the rest queued.
      state     <= S_SHIFT;
      shift_reg <= advance(iData);
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      oSignal   <= head_bit(iData);
      oFrame    <= 1'b1;
      oFirst    <= 1'b1;
      oDone     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          oSignal <= IDLE_LEVEL;
          oFrame  <= 1'b0;
          oFirst  <= 1'b0;
          oDone   <= 1'b0;
        end
        S_SHIFT: begin
          if (!last_bit) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= advance(shift_reg);
            oSignal   <= head_bit(shift_reg);
            oFirst    <= 1'b0;
            oDone     <= (bit_cnt == PENULT_BIT);
          end else begin
            bit_cnt <= '0;
            oSignal <= IDLE_LEVEL;
            oFrame  <= 1'b0;
            oFirst  <= 1'b0;
            oDone   <= 1'b0;
            if (NO_GAP) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (!last_gap) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          oSignal <= IDLE_LEVEL;
          oFrame  <= 1'b0;
          oFirst  <= 1'b0;
          oDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_serializer.sv
// tb_vector_serializer: drives three serializer configurations from one
// stimulus stream (8-bit LSB-first GAP=1, 8-bit MSB-first GAP=0, 2-bit GAP=0)
// and compares every cycle against a frame-level reference model plus a
// downstream collector that rebuilds each word from the serial stream.
module tb_vector_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] rdy, sig, frm, fst, dn;

  always #5 clk = ~clk;

  vector_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(1), .IDLE_LEVEL(0)) u_lsb (
    .iClk(clk), .iRst_n(rst_n), .iData(data), .iValid(valid),
    .oReady(rdy[0]), .oSignal(sig[0]), .oFrame(frm[0]), .oFirst(fst[0]), .oDone(dn[0])
  );

  vector_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(0), .IDLE_LEVEL(0)) u_msb (
    .iClk(clk), .iRst_n(rst_n), .iData(data), .iValid(valid),
    .oReady(rdy[1]), .oSignal(sig[1]), .oFrame(frm[1]), .oFirst(fst[1]), .oDone(dn[1])
  );

  vector_serializer #(.WIDTH(2), .LSB_FIRST(1), .GAP(0), .IDLE_LEVEL(0)) u_w2 (
    .iClk(clk), .iRst_n(rst_n), .iData(data[1:0]), .iValid(valid),
    .oReady(rdy[2]), .oSignal(sig[2]), .oFrame(frm[2]), .oFirst(fst[2]), .oDone(dn[2])
  );

  // Configuration of each instance, as seen by the model.
  int mw[3] = '{8, 8, 2};
  bit ml[3] = '{1'b1, 1'b0, 1'b1};
  int mg[3] = '{1, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle output {signal, frame, first, done}, one entry per cycle.
  logic [3:0] fq [3][32];
  int         frd[3] = '{0, 0, 0};
  int         fwr[3] = '{0, 0, 0};
  // Words accepted and not yet reconstructed by the collector.
  logic [7:0] wq [3][8];
  int         wrd[3] = '{0, 0, 0};
  int         wwr[3] = '{0, 0, 0};
  // Downstream collector state.
  logic [7:0] coll[3];
  int         ccnt[3] = '{0, 0, 0};
  logic [2:0] acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame is WIDTH data cycles in transmit order followed by GAP idle cycles.
  task automatic push_frame(input int i, input logic [7:0] d);
    logic [7:0] mask;
    logic       b;
    for (int n = 0; n < mw[i]; n++) begin
      b = ml[i] ? d[n] : d[mw[i] - 1 - n];
      fq[i][fwr[i] % 32] = {b, 1'b1, (n == 0), (n == mw[i] - 1)};
      fwr[i]++;
    end
    for (int g = 0; g < mg[i]; g++) begin
      fq[i][fwr[i] % 32] = 4'b0000;
      fwr[i]++;
    end
    mask = 8'((32'd1 << mw[i]) - 1);
    wq[i][wwr[i] % 8] = d & mask;
    wwr[i]++;
  endtask

  // One clock cycle: drive inputs, check outputs and ready, update the model.
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    logic [3:0] exp_out;
    logic       exp_rdy;
    int         pos;
    @(negedge clk);
    rst_n = r;
    valid = v;
    data  = d;
    acc   = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (frd[i] != fwr[i]) begin
        exp_out = fq[i][frd[i] % 32];
        frd[i]++;
      end else begin
        exp_out = 4'b0000;
      end
      check($sformatf("out%0d", i), {sig[i], frm[i], fst[i], dn[i]}, exp_out);

      if (frm[i]) begin
        if (fst[i]) begin
          ccnt[i] = 0;
          coll[i] = 8'h00;
        end
        pos = ml[i] ? ccnt[i] : (mw[i] - 1 - ccnt[i]);
        if (pos >= 0 && pos < 8) coll[i][pos] = sig[i];
        ccnt[i]++;
        if (dn[i]) begin
          if (wrd[i] != wwr[i]) begin
            check($sformatf("word%0d", i), coll[i], wq[i][wrd[i] % 8]);
            wrd[i]++;
          end else begin
            check($sformatf("word%0d_unexpected", i), 1, 0);
          end
        end
      end

      exp_rdy = r && (frd[i] == fwr[i]);
      check($sformatf("ready%0d", i), rdy[i], exp_rdy);
      if (!r) begin
        frd[i] = fwr[i];
        wrd[i] = wwr[i];
      end else if (v && exp_rdy) begin
        push_frame(i, d);
        acc[i] = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset held for two cycles, then idle.
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    repeat (3) tick(1'b1, 1'b0, 8'h00);

    // Single frame of 8'hA5.
    tick(1'b1, 1'b1, 8'hA5);
    repeat (12) tick(1'b1, 1'b0, 8'h00);

    // Back-to-back: 8'h0F then 8'hF0 held valid.
    tick(1'b1, 1'b1, 8'h0F);
    repeat (12) tick(1'b1, 1'b1, 8'hF0);
    repeat (12) tick(1'b1, 1'b0, 8'h00);

    // Continuous 8'h81 / 8'h7E stream (GAP=0 instance has no idle between).
    for (int k = 0; k < 24; k++) tick(1'b1, 1'b1, ((k / 8) % 2 == 0) ? 8'h81 : 8'h7E);
    repeat (12) tick(1'b1, 1'b0, 8'h00);

    // Stall: 8'h3C offered mid-frame, then data changed after acceptance.
    tick(1'b1, 1'b1, 8'h11);
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b1, 8'h3C);
      if (acc[0]) break;
    end
    check("stall_accepted", acc[0], 1'b1);
    repeat (12) tick(1'b1, 1'b0, 8'hFF);

    // Reset during bit 3 of 8'hFF, then a clean 8'h01.
    tick(1'b1, 1'b1, 8'hFF);
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h01);
    repeat (12) tick(1'b1, 1'b0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++)
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    repeat (20) tick(1'b1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
